// File: rtl/multi_btn_debounce.sv
// Multi-channel button debouncer: 2-FF synchroniser, shared sample tick,
// per-channel stability qualification, press/release and long-press pulses.
module multi_btn_debounce #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 4,
    parameter int LONG_CNT   = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_long
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(LONG_CNT + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SC_LAST  = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HC_LAST  = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HC_MAX   = HW'(LONG_CNT);

    logic [N_CH-1:0] s1_q, s2_q;
    logic [DW-1:0]   div_q, div_d;
    logic            tick;

    logic [SW-1:0]   sc_q [N_CH];
    logic [SW-1:0]   sc_d [N_CH];
    logic [HW-1:0]   hc_q [N_CH];
    logic [HW-1:0]   hc_d [N_CH];

    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] long_q, long_d;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        long_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sc_d[i] = sc_q[i];
            hc_d[i] = hc_q[i];
            if (tick) begin
                if (s2_q[i] == level_q[i]) begin
                    sc_d[i] = '0;
                end else if (sc_q[i] == SC_LAST) begin
                    level_d[i] = s2_q[i];
                    sc_d[i]    = '0;
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    sc_d[i] = sc_q[i] + 1'b1;
                end
            end
            // hc restarts while released; saturation gives one pulse per press
            if (!level_q[i]) begin
                hc_d[i] = '0;
            end else if (tick && (hc_q[i] < HC_MAX)) begin
                hc_d[i]   = hc_q[i] + 1'b1;
                long_d[i] = (hc_q[i] == HC_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            div_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            long_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                sc_q[i] <= '0;
                hc_q[i] <= '0;
            end
        end else begin
            s1_q    <= i_btn;
            s2_q    <= s1_q;
            div_q   <= div_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
            for (int i = 0; i < N_CH; i++) begin
                sc_q[i] <= sc_d[i];
                hc_q[i] <= hc_d[i];
            end
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_long  = long_q;

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Directed bench for multi_btn_debounce: vector table plus multi-cycle
// sequences on a fast-tick instance and a divided-tick instance.
module tb_multi_btn_debounce;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] level, rise, fall, lng;

    logic       rst1;
    logic [1:0] btn1;
    logic [1:0] level1, rise1, fall1, lng1;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lng;
    } vec_t;

    vec_t vecs [14];

    multi_btn_debounce #(
        .N_CH(4), .TICK_DIV(1), .STABLE_CNT(4), .LONG_CNT(8)
    ) dut0 (
        .clk(clk), .rst(rst), .i_btn(btn),
        .o_level(level), .o_rise(rise), .o_fall(fall), .o_long(lng)
    );

    multi_btn_debounce #(
        .N_CH(2), .TICK_DIV(4), .STABLE_CNT(2), .LONG_CNT(50)
    ) dut1 (
        .clk(clk), .rst(rst1), .i_btn(btn1),
        .o_level(level1), .o_rise(rise1), .o_fall(fall1), .o_long(lng1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (lvl,rise,fall,long)",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] tup0();
        return {level, rise, fall, lng};
    endfunction

    function automatic logic [15:0] tup1();
        return {2'b0, level1, 2'b0, rise1, 2'b0, fall1, 2'b0, lng1};
    endfunction

    task automatic long_seq(input string tag, input int n);
        logic [3:0] el, er, eg;
        int cnt;
        cnt = 0;
        btn = 4'b1000;
        for (int e = 0; e < n; e++) begin
            step();
            el = (e >= 5) ? 4'b1000 : 4'b0000;
            er = (e == 5) ? 4'b1000 : 4'b0000;
            eg = (e == 13) ? 4'b1000 : 4'b0000;
            if (lng[3]) cnt++;
            check($sformatf("%s e%0d", tag, e), tup0(), {el, er, 4'b0, eg});
        end
        check($sformatf("%s long count", tag), 16'(cnt), 16'd1);
    endtask

    initial begin
        logic [3:0] pat;
        int d;
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        rst1 = 1'b1;
        btn  = '0;
        btn1 = 2'b01;

        for (int e = 0; e < 7; e++)
            vecs[e] = '{4'b0001, (e >= 5) ? 4'b0001 : 4'b0000,
                        (e == 5) ? 4'b0001 : 4'b0000, 4'b0, 4'b0};
        for (int e = 0; e < 7; e++)
            vecs[7+e] = '{4'b0000, (e < 5) ? 4'b0001 : 4'b0000, 4'b0,
                          (e == 5) ? 4'b0001 : 4'b0000, 4'b0};

        repeat (3) step();
        check("reset dut0", tup0(), 16'h0);
        check("reset dut1", tup1(), 16'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // clean press then release of ch0, one vector per edge
        for (int i = 0; i < 14; i++) begin
            btn = vecs[i].btn;
            step();
            check($sformatf("vec%0d", i), tup0(),
                  {vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].lng});
        end

        // bounce on ch1: 1,1,1,0 never qualifies
        for (int c = 0; c < 40; c++) begin
            btn = ((c % 4) == 3) ? 4'b0000 : 4'b0010;
            step();
            check($sformatf("bounce c%0d", c), tup0(), 16'h0);
        end
        btn = 4'b0010;
        for (int e = 1; e <= 7; e++) begin
            step();
            pat = (e == 6) ? 4'b0010 : 4'b0000;
            check($sformatf("bounce hold e%0d", e), tup0(),
                  {(e >= 6) ? 4'b0010 : 4'b0000, pat, 4'b0, 4'b0});
        end
        btn = 4'b0000;
        repeat (10) step();

        // simultaneous release of ch0 and ch2
        btn = 4'b0101;
        repeat (20) step();
        check("simul held", {12'h0, level}, {12'h0, 4'b0101});
        btn = 4'b0000;
        for (int e = 0; e < 7; e++) begin
            step();
            check($sformatf("simul rel e%0d", e), tup0(),
                  {(e < 5) ? 4'b0101 : 4'b0000, 4'b0,
                   (e == 5) ? 4'b0101 : 4'b0000, 4'b0});
        end

        // long press, release, re-press
        long_seq("long1", 114);
        btn = 4'b0000;
        repeat (10) step();
        long_seq("long2", 20);
        btn = 4'b0000;
        repeat (10) step();

        // asynchronous reset while ch0 held
        btn = 4'b0001;
        repeat (8) step();
        check("pre-reset level", {12'h0, level}, {12'h0, 4'b0001});
        @(posedge clk);
        d = $urandom_range(1, 7);
        #d rst = 1'b1;
        #1;
        check("async reset", tup0(), 16'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        for (int e = 0; e < 7; e++) begin
            step();
            check($sformatf("post-reset e%0d", e), tup0(),
                  {(e >= 5) ? 4'b0001 : 4'b0000,
                   (e == 5) ? 4'b0001 : 4'b0000, 4'b0, 4'b0});
        end
        btn = 4'b0000;

        // divided tick: changes only on edges where div was 3
        @(posedge clk);
        #2 rst1 = 1'b0;
        for (int e = 0; e < 21; e++) begin
            if (e == 10) btn1 = 2'b00;
            step();
            check($sformatf("div e%0d", e), tup1(),
                  {2'b0, (e >= 7 && e < 19) ? 2'b01 : 2'b00,
                   2'b0, (e == 7) ? 2'b01 : 2'b00,
                   2'b0, (e == 19) ? 2'b01 : 2'b00,
                   4'h0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
